// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Main control unit for a multicycle RV32I datapath. Steps each instruction
//   through fetch/decode/execute/memory/writeback, drives the datapath strobes
//   and mux selects, emits the ALUop class for the ALU control decoder, stalls
//   on mem_ready and counts retired instructions.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   opcode, funct3           instruction fields from the IR
//   zero                     ALU zero flag (branch resolution)
//   mem_ready                memory access completes this cycle
//   ALUop                    000 add, 001 branch, 010 load, 011 store, 100 R/I
//   pc_write, ir_write       PC / IR load enables
//   mem_read, mem_write      memory strobes
//   i_or_d                   memory address select (0=PC, 1=ALUOut)
//   alu_src_a, alu_src_b     ALU operand selects
//   mem_to_reg, pc_src       writeback / PC source selects
//   reg_write                register file write enable
//   illegal                  one-cycle pulse on unsupported opcode
//   state                    current state encoding (debug)
//   retired                  retired-instruction count, wraps
module multicycle_control_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       ALUop,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             mem_to_reg,
  output logic             pc_src,
  output logic             reg_write,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ILLEGAL  = 4'd9
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    ALUop      = 3'b000;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while the opcode decodes.
        alu_src_b = 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R, OP_I:        state_d = S_EXECUTE;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_STORE) begin
          ALUop   = 3'b011;
          state_d = S_MEMWRITE;
        end else begin
          ALUop   = 3'b010;
          state_d = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        ALUop     = 3'b100;
        alu_src_b = (opcode == OP_I) ? 2'b10 : 2'b00;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        ALUop     = 3'b001;
        pc_src    = 1'b1;
        pc_write  = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
        state_d   = S_FETCH;
        retire    = 1'b1;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset overrides every strobe, even mid-access.
    if (rst) begin
      ALUop      = 3'b000;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      mem_to_reg = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm
//   Directed bench for multicycle_control_fsm. Instructions are expanded into
//   their per-cycle phase sequence (including stall cycles); each cycle's
//   expected state, outputs and retired count are queued and checked on the
//   falling edge.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        zero;
  logic        mem_ready;
  logic [2:0]  ALUop;
  logic        pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src_a;
  logic [1:0]  alu_src_b;
  logic        mem_to_reg, pc_src, reg_write, illegal;
  logic [3:0]  state;
  logic [31:0] retired;

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .ALUop(ALUop), .pc_write(pc_write),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .mem_to_reg(mem_to_reg), .pc_src(pc_src), .reg_write(reg_write),
    .illegal(illegal), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef enum int {
    P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
    P_MEMWRITE = 5, P_EXEC = 6, P_ALUWB = 7, P_BRANCH = 8, P_ILL = 9
  } phase_e;

  typedef struct {
    int          st;
    logic [14:0] outs;
    logic [31:0] ret;
    string       tag;
  } exp_t;

  exp_t        expq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_ret = '0;

  function automatic logic [14:0] pack(logic [2:0] aop, logic pcw, logic irw,
      logic mr, logic mw, logic iod, logic asa, logic [1:0] asb, logic m2r,
      logic pcs, logic rw, logic ill);
    return {aop, pcw, irw, mr, mw, iod, asa, asb, m2r, pcs, rw, ill};
  endfunction

  // Expected strobes for one cycle of a given phase.
  function automatic logic [14:0] spec_out(phase_e p, logic rdy, logic [6:0] op,
                                           logic [2:0] f3, logic z);
    case (p)
      P_FETCH:    return pack(3'b000, rdy, rdy, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0);
      P_DECODE:   return pack(3'b000, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0);
      P_MEMADR:   return pack((op == 7'b0100011) ? 3'b011 : 3'b010,
                              0, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0);
      P_MEMREAD:  return pack(3'b000, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0);
      P_MEMWB:    return pack(3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0);
      P_MEMWRITE: return pack(3'b000, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0);
      P_EXEC:     return pack(3'b100, 0, 0, 0, 0, 0, 1,
                              (op == 7'b0010011) ? 2'b10 : 2'b00, 0, 0, 0, 0);
      P_ALUWB:    return pack(3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
      P_BRANCH:   return pack(3'b001, ((f3 == 3'b000) && z) || ((f3 == 3'b001) && !z),
                              0, 0, 0, 0, 1, 2'b00, 0, 1, 0, 0);
      P_ILL:      return pack(3'b000, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
      default:    return '0;
    endcase
  endfunction

  // One normal cycle: drive inputs, queue the expectation, advance.
  task automatic cyc(phase_e p, logic rdy, string tag);
    exp_t e;
    rst       = 1'b0;
    mem_ready = rdy;
    e.st   = int'(p);
    e.outs = spec_out(p, rdy, opcode, funct3, zero);
    e.ret  = model_ret;
    e.tag  = tag;
    expq.push_back(e);
    @(posedge clk); #1;
  endtask

  // One reset cycle: strobes forced to zero, state/count cleared at the edge.
  task automatic rst_cyc(phase_e cur, string tag);
    exp_t e;
    rst       = 1'b1;
    mem_ready = 1'b1;
    e.st   = int'(cur);
    e.outs = '0;
    e.ret  = model_ret;
    e.tag  = tag;
    expq.push_back(e);
    @(posedge clk); #1;
    model_ret = '0;
  endtask

  // Expand one instruction into its phase sequence.
  task automatic run_instr(logic [6:0] op, logic [2:0] f3, logic z,
                           int fstall, int mstall, string tag);
    opcode = op;
    funct3 = f3;
    zero   = z;
    for (int i = 0; i < fstall; i++) cyc(P_FETCH, 1'b0, tag);
    cyc(P_FETCH, 1'b1, tag);
    cyc(P_DECODE, 1'b0, tag);
    case (op)
      7'b0000011: begin
        cyc(P_MEMADR, 1'b0, tag);
        for (int i = 0; i < mstall; i++) cyc(P_MEMREAD, 1'b0, tag);
        cyc(P_MEMREAD, 1'b1, tag);
        cyc(P_MEMWB, 1'b0, tag);
        model_ret = model_ret + 32'd1;
      end
      7'b0100011: begin
        cyc(P_MEMADR, 1'b0, tag);
        for (int i = 0; i < mstall; i++) cyc(P_MEMWRITE, 1'b0, tag);
        cyc(P_MEMWRITE, 1'b1, tag);
        model_ret = model_ret + 32'd1;
      end
      7'b0110011, 7'b0010011: begin
        cyc(P_EXEC, 1'b0, tag);
        cyc(P_ALUWB, 1'b0, tag);
        model_ret = model_ret + 32'd1;
      end
      7'b1100011: begin
        cyc(P_BRANCH, 1'b0, tag);
        model_ret = model_ret + 32'd1;
      end
      default: cyc(P_ILL, 1'b1, tag);
    endcase
  endtask

  task automatic check_lit(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Compare process: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    logic [14:0] act;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e   = expq.pop_front();
        act = pack(ALUop, pc_write, ir_write, mem_read, mem_write, i_or_d,
                   alu_src_a, alu_src_b, mem_to_reg, pc_src, reg_write, illegal);
        n_cmp++;
        if (int'(state) != e.st) begin
          n_bad++;
          $display("FAIL %s state: got %0d expected %0d", e.tag, state, e.st);
        end
        n_cmp++;
        if (act !== e.outs) begin
          n_bad++;
          $display("FAIL %s outs: got %b expected %b", e.tag, act, e.outs);
        end
        n_cmp++;
        if (retired !== e.ret) begin
          n_bad++;
          $display("FAIL %s retired: got %0d expected %0d", e.tag, retired, e.ret);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; opcode = 7'b0110011; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    rst_cyc(P_FETCH, "reset0");
    rst_cyc(P_FETCH, "reset1");
    check_lit("reset_retired", retired, 32'd0);

    run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, "rtype");
    check_lit("ret_after_rtype", retired, 32'd1);
    run_instr(7'b0010011, 3'b000, 1'b0, 0, 0, "itype");

    run_instr(7'b0000011, 3'b010, 1'b0, 0, 0, "load");
    run_instr(7'b0100011, 3'b010, 1'b0, 0, 0, "store");
    check_lit("ret_after_ldst", retired, 32'd4);

    run_instr(7'b1100011, 3'b000, 1'b1, 0, 0, "beq_taken");
    run_instr(7'b1100011, 3'b001, 1'b1, 0, 0, "bne_not");
    run_instr(7'b1100011, 3'b000, 1'b0, 0, 0, "beq_not");
    run_instr(7'b1100011, 3'b001, 1'b0, 0, 0, "bne_taken");
    run_instr(7'b1100011, 3'b100, 1'b1, 0, 0, "blt_nopc");
    check_lit("ret_after_br", retired, 32'd9);

    run_instr(7'b0110011, 3'b000, 1'b0, 3, 0, "fetch_stall");
    run_instr(7'b0000011, 3'b010, 1'b0, 0, 2, "memrd_stall");
    run_instr(7'b0100011, 3'b010, 1'b0, 0, 1, "memwr_stall");
    check_lit("ret_after_stall", retired, 32'd12);

    run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, "illegal");
    check_lit("ret_after_ill", retired, 32'd12);
    check_lit("state_after_ill", {28'd0, state}, 32'd0);

    // Reset while a load waits on memory.
    opcode = 7'b0000011; funct3 = 3'b010; zero = 1'b0;
    cyc(P_FETCH, 1'b1, "rst_mid");
    cyc(P_DECODE, 1'b0, "rst_mid");
    cyc(P_MEMADR, 1'b0, "rst_mid");
    cyc(P_MEMREAD, 1'b0, "rst_mid");
    rst_cyc(P_MEMREAD, "rst_mid_r0");
    rst_cyc(P_FETCH, "rst_mid_r1");
    check_lit("ret_after_rst_mid", retired, 32'd0);

    run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, "post_rst");
    check_lit("ret_post_rst", retired, 32'd1);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
